// File: rtl/ensemble_vote_combiner.sv
// ---------------------------------------------------------------------------
// ensemble_vote_combiner
//
// Purpose:
//   Combines the per-sample class labels produced by three classifiers into a
//   single majority-voted AXI-Stream result.
//   - Each classifier input has its own 2-entry FIFO.
//   - A vote fires once every FIFO holds a beat and the output register can
//     accept a new value.
//   - If all three labels differ, classifier 1 wins the tie.
//   - Tracks sets whose three tlast flags disagree (sticky tlast_err).
//   - Counts three-way disagreements in disagree_cnt, which saturates.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous active-high reset
//   s_axis_*_1/_2/_3         classifier result streams (tkeep is ignored)
//   m_axis_*                 voted result stream. tdata carries the zero-
//                            extended label, tkeep is all ones, and tlast is
//                            taken from classifier 1.
//   tlast_err                sticky: a voted set had differing tlast flags
//   disagree_cnt             saturating count of three-distinct-label votes
//
// Configuration macro:
//   VOTE_CONFIDENCE_EN  when defined, tdata[CLASS_WIDTH+1:CLASS_WIDTH] holds
//                       the agreement count (3 unanimous, 2 majority,
//                       1 all distinct). When undefined, those bits are zero.
// ---------------------------------------------------------------------------
module ensemble_vote_combiner #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  input  logic                  s_axis_tlast_1,
  output logic                  s_axis_tready_1,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  input  logic                  s_axis_tlast_2,
  output logic                  s_axis_tready_2,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
  input  logic                  s_axis_tvalid_3,
  input  logic                  s_axis_tlast_3,
  output logic                  s_axis_tready_3,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,

  output logic                  tlast_err,
  output logic [15:0]           disagree_cnt
);

  localparam int NUM_IN = 3;
  localparam int DEPTH  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Input gathering: bring the three named streams into indexable arrays.
  // -------------------------------------------------------------------------
  logic [CLASS_WIDTH-1:0] in_label   [NUM_IN];
  logic                   in_last    [NUM_IN];
  logic                   in_valid   [NUM_IN];
  logic                   in_ready   [NUM_IN];
  logic [CLASS_WIDTH-1:0] head_label [NUM_IN];
  logic                   head_last  [NUM_IN];
  logic                   not_empty  [NUM_IN];
  logic                   vote_fire;

  assign in_label[0] = s_axis_tdata_1[CLASS_WIDTH-1:0];
  assign in_label[1] = s_axis_tdata_2[CLASS_WIDTH-1:0];
  assign in_label[2] = s_axis_tdata_3[CLASS_WIDTH-1:0];
  assign in_last[0]  = s_axis_tlast_1;
  assign in_last[1]  = s_axis_tlast_2;
  assign in_last[2]  = s_axis_tlast_3;
  assign in_valid[0] = s_axis_tvalid_1;
  assign in_valid[1] = s_axis_tvalid_2;
  assign in_valid[2] = s_axis_tvalid_3;

  assign s_axis_tready_1 = in_ready[0];
  assign s_axis_tready_2 = in_ready[1];
  assign s_axis_tready_3 = in_ready[2];

  // tkeep and the tdata bits above the label carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3,
                           s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH],
                           s_axis_tdata_3[DATA_WIDTH-1:CLASS_WIDTH]};

  // -------------------------------------------------------------------------
  // Per-input 2-entry FIFOs (label + tlast).
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_fifo
      logic [1:0]             count_reg;
      logic [1:0]             count_next;
      logic                   wr_ptr_reg;
      logic                   rd_ptr_reg;
      logic                   wr_en;
      logic [CLASS_WIDTH-1:0] label_mem [DEPTH];
      logic                   last_mem  [DEPTH];

      // Ready comes only from the registered count. A full FIFO that is being
      // popped this cycle still reports not-ready. Ready is forced low while
      // reset is held.
      assign in_ready[gi]  = ~rst & (count_reg != 2'd2);
      assign wr_en         = in_valid[gi] & in_ready[gi];
      assign not_empty[gi] = (count_reg != 2'd0);
      assign head_label[gi] = label_mem[rd_ptr_reg];
      assign head_last[gi]  = last_mem[rd_ptr_reg];

      always_comb begin
        count_next = count_reg;
        case ({wr_en, vote_fire})
          2'b10:   count_next = count_reg + 2'd1;
          2'b01:   count_next = count_reg - 2'd1;
          default: count_next = count_reg;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg  <= 2'd0;
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
        end else begin
          count_reg <= count_next;
          if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
          if (vote_fire) rd_ptr_reg <= ~rd_ptr_reg;
        end
      end

      // Storage needs no reset: the occupancy count decides what is valid.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          label_mem[wr_ptr_reg] <= in_label[gi];
          last_mem[wr_ptr_reg]  <= in_last[gi];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Vote logic on the three FIFO heads.
  // -------------------------------------------------------------------------
  logic                   eq_ab;
  logic                   eq_ac;
  logic                   eq_bc;
  logic                   all_distinct;
  logic                   last_mismatch;
  logic [CLASS_WIDTH-1:0] voted_label;
  logic [DATA_WIDTH-1:0]  data_next;

  assign eq_ab = (head_label[0] == head_label[1]);
  assign eq_ac = (head_label[0] == head_label[2]);
  assign eq_bc = (head_label[1] == head_label[2]);
  assign all_distinct  = ~eq_ab & ~eq_ac & ~eq_bc;
  assign last_mismatch = ~((head_last[0] == head_last[1]) &&
                           (head_last[1] == head_last[2]));

  // Classifier 2 wins only when it agrees with classifier 3 against
  // classifier 1. Every other case, including a three-way split, goes to
  // classifier 1.
  assign voted_label = (~eq_ab & ~eq_ac & eq_bc) ? head_label[1] : head_label[0];

`ifdef VOTE_CONFIDENCE_EN
  logic [1:0] agree_cnt;
  always_comb begin
    agree_cnt = 2'd2;
    if (eq_ab && eq_ac)    agree_cnt = 2'd3;
    else if (all_distinct) agree_cnt = 2'd1;
  end
`endif

  always_comb begin
    data_next = '0;
    data_next[CLASS_WIDTH-1:0] = voted_label;
`ifdef VOTE_CONFIDENCE_EN
    data_next[CLASS_WIDTH+1:CLASS_WIDTH] = agree_cnt;
`endif
  end

  // -------------------------------------------------------------------------
  // Output register FSM: state register / next-state / outputs.
  // -------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;
  logic   all_not_empty;

  assign all_not_empty = not_empty[0] & not_empty[1] & not_empty[2];
  // A held beat leaving this cycle frees the register for the next vote, so
  // throughput stays at one vote per cycle.
  assign vote_fire = all_not_empty & ((state_reg == EMPTY) | m_axis_tready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (vote_fire) state_next = HOLD;
      HOLD:    if (!vote_fire && m_axis_tready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state_reg == HOLD);
  end

  // -------------------------------------------------------------------------
  // Output payload, sticky error and disagreement counter.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_reg;
  logic [KEEP_WIDTH-1:0] keep_reg;
  logic                  last_reg;
  logic                  err_reg;
  logic [15:0]           cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      keep_reg <= '0;
      last_reg <= 1'b0;
      err_reg  <= 1'b0;
      cnt_reg  <= 16'd0;
    end else if (vote_fire) begin
      data_reg <= data_next;
      keep_reg <= '1;
      last_reg <= head_last[0];
      if (last_mismatch) err_reg <= 1'b1;
      if (all_distinct && cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign m_axis_tdata = data_reg;
  assign m_axis_tkeep = keep_reg;
  assign m_axis_tlast = last_reg;
  assign tlast_err    = err_reg;
  assign disagree_cnt = cnt_reg;

endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// ---------------------------------------------------------------------------
// tb_ensemble_vote_combiner
//
// Purpose:
//   Directed self-checking bench for ensemble_vote_combiner.
//   - Each scenario task drives its own stimulus and checks the outputs
//     against hand-computed values.
//   - Expected tdata accounts for VOTE_CONFIDENCE_EN when that macro is
//     defined.
// ---------------------------------------------------------------------------
module tb_ensemble_vote_combiner;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] tdata  [3];
  logic          tvalid [3];
  logic          tlast  [3];
  logic          tready [3];
  logic [KW-1:0] keep_in = 4'hA;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic          tlast_err;
  logic [15:0]   disagree_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ensemble_vote_combiner #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_1(tdata[0]), .s_axis_tkeep_1(keep_in), .s_axis_tvalid_1(tvalid[0]),
    .s_axis_tlast_1(tlast[0]), .s_axis_tready_1(tready[0]),
    .s_axis_tdata_2(tdata[1]), .s_axis_tkeep_2(keep_in), .s_axis_tvalid_2(tvalid[1]),
    .s_axis_tlast_2(tlast[1]), .s_axis_tready_2(tready[1]),
    .s_axis_tdata_3(tdata[2]), .s_axis_tkeep_3(keep_in), .s_axis_tvalid_3(tvalid[2]),
    .s_axis_tlast_3(tlast[2]), .s_axis_tready_3(tready[2]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .tlast_err(tlast_err), .disagree_cnt(disagree_cnt)
  );

  // Expected tdata for a given label and agreement count.
  function automatic logic [DW-1:0] exp_data(input int label, input int conf);
`ifdef VOTE_CONFIDENCE_EN
    return DW'((conf << CW) | label);
`else
    return DW'(label + 0 * conf);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tvalid[k] = 1'b0;
      tdata[k]  = '0;
      tlast[k]  = 1'b0;
    end
  endtask

  // Present one beat on every input for a single edge (inputs assumed ready).
  task automatic send_set(input int l0, input int l1, input int l2,
                          input logic t0, input logic t1, input logic t2);
    tdata[0] = DW'(l0); tdata[1] = DW'(l1); tdata[2] = DW'(l2);
    tlast[0] = t0;      tlast[1] = t1;      tlast[2] = t2;
    for (int k = 0; k < 3; k++) tvalid[k] = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    m_tready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({tready[0], tready[1], tready[2]} !== 3'b000) begin
      $display("FAIL reset_tready: got %b expected 000", {tready[0], tready[1], tready[2]});
      fails++;
    end
    tests++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0) begin
      $display("FAIL reset_out: got v=%b d=%h k=%h l=%b expected all zero",
               m_tvalid, m_tdata, m_tkeep, m_tlast);
      fails++;
    end
    tests++;
    if (tlast_err !== 1'b0 || disagree_cnt !== 16'd0) begin
      $display("FAIL reset_status: got err=%b cnt=%0d expected 0/0", tlast_err, disagree_cnt);
      fails++;
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({tready[0], tready[1], tready[2]} !== 3'b111) begin
      $display("FAIL release_tready: got %b expected 111", {tready[0], tready[1], tready[2]});
      fails++;
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_unanimous();
    m_tready = 1'b1;
    send_set(5, 5, 5, 1'b0, 1'b0, 1'b0);
    tests++;
    if (m_tvalid !== 1'b0) begin
      $display("FAIL unan_latency_early: got tvalid=%b expected 0", m_tvalid);
      fails++;
    end
    tick();
    tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_data(5, 3) || m_tkeep !== 4'hF) begin
      $display("FAIL unan_out: got v=%b d=%h k=%h expected v=1 d=%h k=f",
               m_tvalid, m_tdata, m_tkeep, exp_data(5, 3));
      fails++;
    end
    tick();
    tests++;
    if (m_tvalid !== 1'b0) begin
      $display("FAIL unan_drain: got tvalid=%b expected 0", m_tvalid);
      fails++;
    end
    $display("[TB] test_unanimous: 5,5,5 -> %h", exp_data(5, 3));
  endtask

  task automatic test_late_input();
    bit early_ok = 1;
    m_tready = 1'b1;
    tdata[1] = DW'(7); tdata[2] = DW'(7);
    tvalid[1] = 1'b1;  tvalid[2] = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (m_tvalid !== 1'b0) early_ok = 0;
      if (i < 3) tick();
    end
    tests++;
    if (!early_ok) begin
      $display("FAIL late_no_early_vote: got an output before input 1 arrived, expected none");
      fails++;
    end
    tdata[0] = DW'(3); tvalid[0] = 1'b1;
    tick();
    idle_inputs();
    tick();
    tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_data(7, 2)) begin
      $display("FAIL late_out: got v=%b d=%h expected v=1 d=%h", m_tvalid, m_tdata, exp_data(7, 2));
      fails++;
    end
    tick();
    $display("[TB] test_late_input: 3,7,7 -> %h", exp_data(7, 2));
  endtask

  task automatic test_disagree();
    m_tready = 1'b1;
    send_set(1, 2, 4, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_data(1, 1)) begin
      $display("FAIL disagree_out: got v=%b d=%h expected v=1 d=%h", m_tvalid, m_tdata, exp_data(1, 1));
      fails++;
    end
    tests++;
    if (disagree_cnt !== 16'd1) begin
      $display("FAIL disagree_cnt: got %0d expected 1", disagree_cnt);
      fails++;
    end
    tick();
    $display("[TB] test_disagree: 1,2,4 -> %h cnt=%0d", exp_data(1, 1), disagree_cnt);
  endtask

  task automatic test_backpressure();
    int   acc [3];
    logic snap [3];
    bit   stable_ok = 1;
    int   expect_lbl [3] = '{10, 11, 12};
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      acc[k] = 0;
      tvalid[k] = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++) begin
        tdata[k] = DW'(10 + acc[k]);
        snap[k]  = tready[k];
      end
      tick();
      for (int k = 0; k < 3; k++) if (snap[k]) acc[k]++;
      if (i >= 1 && (m_tvalid !== 1'b1 || m_tdata !== exp_data(10, 3))) stable_ok = 0;
    end
    idle_inputs();
    tests++;
    if (acc[0] != 3 || acc[1] != 3 || acc[2] != 3) begin
      $display("FAIL bp_accepted: got %0d/%0d/%0d expected 3/3/3", acc[0], acc[1], acc[2]);
      fails++;
    end
    tests++;
    if ({tready[0], tready[1], tready[2]} !== 3'b000) begin
      $display("FAIL bp_tready: got %b expected 000", {tready[0], tready[1], tready[2]});
      fails++;
    end
    tests++;
    if (!stable_ok) begin
      $display("FAIL bp_stable: got output change while stalled, expected stable %h", exp_data(10, 3));
      fails++;
    end
    m_tready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_data(expect_lbl[j], 3)) begin
        $display("FAIL bp_drain_%0d: got v=%b d=%h expected v=1 d=%h",
                 j, m_tvalid, m_tdata, exp_data(expect_lbl[j], 3));
        fails++;
      end
      tick();
    end
    tests++;
    if (m_tvalid !== 1'b0) begin
      $display("FAIL bp_empty: got tvalid=%b expected 0", m_tvalid);
      fails++;
    end
    $display("[TB] test_backpressure: 3 beats per input accepted, drained 10,11,12");
  endtask

  task automatic test_tlast_err();
    m_tready = 1'b1;
    tests++;
    if (tlast_err !== 1'b0) begin
      $display("FAIL tlast_err_pre: got %b expected 0", tlast_err);
      fails++;
    end
    send_set(20, 20, 20, 1'b1, 1'b0, 1'b1);
    tick();
    tests++;
    if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || tlast_err !== 1'b1) begin
      $display("FAIL tlast_mixed: got v=%b last=%b err=%b expected 1/1/1", m_tvalid, m_tlast, tlast_err);
      fails++;
    end
    tick();
    send_set(21, 21, 21, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if (m_tdata !== exp_data(21, 3) || m_tlast !== 1'b0 || tlast_err !== 1'b1) begin
      $display("FAIL tlast_sticky: got d=%h last=%b err=%b expected d=%h last=0 err=1",
               m_tdata, m_tlast, tlast_err, exp_data(21, 3));
      fails++;
    end
    tick();
    $display("[TB] test_tlast_err: sticky flag held");
  endtask

  task automatic test_reset_midstream();
    bit quiet_ok = 1;
    m_tready = 1'b0;
    send_set(30, 30, 30, 1'b0, 1'b0, 1'b0);
    send_set(31, 31, 31, 1'b0, 1'b0, 1'b0);
    send_set(32, 32, 32, 1'b0, 1'b0, 1'b0);
    tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_data(30, 3)) begin
      $display("FAIL mid_hold: got v=%b d=%h expected v=1 d=%h", m_tvalid, m_tdata, exp_data(30, 3));
      fails++;
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (m_tvalid !== 1'b0 || tready[0] !== 1'b0) begin
      $display("FAIL mid_rst_async: got v=%b tready1=%b expected 0/0", m_tvalid, tready[0]);
      fails++;
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if ({tready[0], tready[1], tready[2]} !== 3'b111) begin
      $display("FAIL mid_release_tready: got %b expected 111", {tready[0], tready[1], tready[2]});
      fails++;
    end
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_tvalid !== 1'b0) quiet_ok = 0;
    end
    tests++;
    if (!quiet_ok || tlast_err !== 1'b0 || disagree_cnt !== 16'd0) begin
      $display("FAIL mid_quiet: got quiet=%0d err=%b cnt=%0d expected 1/0/0",
               quiet_ok, tlast_err, disagree_cnt);
      fails++;
    end
    send_set(40, 40, 40, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== exp_data(40, 3)) begin
      $display("FAIL mid_fresh: got v=%b d=%h expected v=1 d=%h", m_tvalid, m_tdata, exp_data(40, 3));
      fails++;
    end
    tick();
    $display("[TB] test_reset_midstream: buffered beats discarded, fresh 40 emitted");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_unanimous();
    test_late_input();
    test_disagree();
    test_backpressure();
    test_tlast_err();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
